softmax_sequencer: RTL and testbench
====================================

// Module: softmax_sequencer
// PURPOSE
//   Frame-level controller for the FP32 softmax datapath. It buffers a frame of N IEEE-754 inputs
//   and tracks the running maximum while loading. It then schedules one shared FP unit (SUB/EXP/ADD/DIV)
//   through a req/done handshake to compute exp(x_i-max)/sum and stream N results.
//   It sits between the output layer of the MNIST accelerator and the classification logic.
// PARAMETERS
//   N     4   elements per frame (>=2); index width IW=$clog2(N)
// PORTS
//   clk        in   1   single clock, all logic on posedge
//   rst        in   1   synchronous, active-high reset
//   valid_in   in   1   data_in valid; accepted when valid_in & in_ready
//   data_in    in   32  FP32 input element
//   in_ready   out  1   high only in S_LOAD
//   fu_req     out  1   FP unit request; level, held until fu_done
//   fu_op      out  2   0=SUB(a-b) 1=EXP(a) 2=ADD(a+b) 3=DIV(a/b)
//   fu_a       out  32  operand A, stable while fu_req=1
//   fu_b       out  32  operand B, stable while fu_req=1 (0 for EXP)
//   fu_done    in   1   1-cycle pulse; fu_result valid same cycle
//   fu_result  in   32  FP unit result
//   softmax_out out 32  FP32 output element
//   valid_out  out  1   1-cycle pulse per output, no backpressure
//   out_idx    out  IW  element index of softmax_out
//   out_last   out  1   high with valid_out for element N-1
//   busy       out  1   high in every state except S_LOAD
// BEHAVIOUR
//   Reset: state=S_LOAD, idx=0, max=0xFF800000 (-inf), sum=0x00000000. in_ready=1.
//     All other outputs are 0. Buffer contents are don't-care. Reset mid-frame aborts the frame
//     and drops any in-flight fu_done.
//   Max compare: key(x)=x[31]?~x:(x^32'h80000000). On acceptance, max<=data_in if key(data_in)>key(max).
//     The comparison is unsigned, so -0<+0. NaN handling is out of scope.
//   FSM (idx counts 0..N-1 and wraps to 0 on each phase change):
//     S_LOAD : on accept, buf[idx]<=data_in and update max. When the Nth element is accepted,
//              go to S_SUB with idx=0.
//     S_SUB  : issue SUB(buf[idx], max). On done, tmp<=result and go to S_EXP.
//     S_EXP  : issue EXP(tmp). On done, buf[idx]<=result (in place) and go to S_ACC.
//     S_ACC  : issue ADD(sum, buf[idx]). On done, sum<=result. If idx==N-1, go to S_DIV with idx=0.
//              Otherwise increment idx and go to S_SUB.
//     S_DIV  : issue DIV(buf[idx], sum). On done, register the output: softmax_out<=result,
//              out_idx<=idx, valid_out=1 in the next cycle, out_last=(idx==N-1).
//              If idx==N-1, go to S_LOAD and reset max and sum. Otherwise increment idx.
//   Handshake timing:
//     - fu_req rises 1 cycle after the state is entered and the previous result is captured.
//       fu_op/fu_a/fu_b are registered and valid in the same cycle that fu_req rises.
//     - The result is captured on the posedge where fu_req&fu_done.
//     - fu_req is low for at least 1 cycle between operations.
//     - fu_done while fu_req=0 is ignored.
//     - For an FU that returns done L>=1 cycles after req rises, each op costs L+2 cycles.
//   Frame latency (last accept to last valid_out) = 4N*(L+2) cycles.
//   valid_in while busy: ignored, not buffered, in_ready=0.
//   The first element of the next frame can be accepted in the cycle after out_last.
//   Accept and state change in the same cycle: the Nth accept takes effect and the state moves
//   to S_SUB. A simultaneous next valid_in is not accepted.
// TESTING
//   1. Four inputs of 1.0 (0x3F800000), FU model L=1:
//      - each SUB has fu_b=0x3F800000;
//      - four valid_out pulses carry 0x3E800000 with out_idx 0..3, out_last on idx 3;
//      - last output follows last accept by 48 cycles.
//   2. Inputs -2.0,-1.0,-3.0,-0.5 (0xC0000000,0xBF800000,0xC0400000,0xBF000000):
//      - every SUB has fu_b=0xBF000000;
//      - the EXP issued for idx 3 has fu_a=0x00000000 (exp(0)=1).
//   3. Random FU latency of 1..8 with op/operands checked stable while req is high:
//      - outputs match a real-arithmetic softmax within 2 ulp;
//      - a spurious fu_done with req low changes nothing.
//   4. valid_in held high throughout:
//      - exactly N elements are accepted per frame;
//      - in_ready=0 from the cycle after the Nth accept until after out_last;
//      - the next frame loads back-to-back.
//   5. Assert rst during S_EXP of idx 2:
//      - next cycle state=S_LOAD, fu_req=0, valid_out=0, in_ready=1;
//      - a fresh frame of four 1.0 yields four 0x3E800000.
//   6. Inputs +0.0 and -0.0 mixed with -1.0 (N=4): max register captures 0x00000000 (+0).
// (end of specification)

Source files
------------

// File: rtl/softmax_sequencer.sv
// Frame-level softmax controller: buffers N FP32 inputs, tracks their maximum, then drives one
// shared FP unit through SUB/EXP/ADD/DIV per element to stream exp(x_i - max) / sum.
module softmax_sequencer #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_in,
    input  logic [31:0]   data_in,
    output logic          in_ready,
    output logic          fu_req,
    output logic [1:0]    fu_op,
    output logic [31:0]   fu_a,
    output logic [31:0]   fu_b,
    input  logic          fu_done,
    input  logic [31:0]   fu_result,
    output logic [31:0]   softmax_out,
    output logic          valid_out,
    output logic [IW-1:0] out_idx,
    output logic          out_last,
    output logic          busy
);

    typedef enum logic [2:0] {S_LOAD, S_SUB, S_EXP, S_ACC, S_DIV} state_t;
    typedef enum logic [1:0] {OP_SUB, OP_EXP, OP_ADD, OP_DIV} fu_op_t;

    localparam logic [31:0]   NEG_INF  = 32'hFF80_0000;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    state_t        state, state_n;
    logic [IW-1:0] idx, idx_n;
    logic [31:0]   max_q, sum_q, tmp_q;
    logic [31:0]   frame_buf [N];
    fu_op_t        op_n;
    logic [31:0]   a_n, b_n;
    logic          accept, fire, issue, last_idx, step;

    // Maps FP32 bit patterns onto an unsigned order, so -0 sorts just below +0.
    function automatic logic [31:0] order_key(input logic [31:0] x);
        return x[31] ? ~x : (x ^ 32'h8000_0000);
    endfunction

    assign in_ready = (state == S_LOAD);
    assign busy     = ~in_ready;
    assign accept   = valid_in & in_ready;
    assign fire     = fu_req & fu_done;
    assign issue    = (state != S_LOAD) & ~fu_req;
    assign last_idx = (idx == LAST_IDX);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= S_LOAD;
        else     state <= state_n;
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_n = state;
        idx_n   = idx;
        step    = 1'b0;
        op_n    = OP_SUB;
        a_n     = '0;
        b_n     = '0;
        case (state)
            S_LOAD: begin
                step = accept;
                if (accept && last_idx) state_n = S_SUB;
            end
            S_SUB: begin
                op_n = OP_SUB;
                a_n  = frame_buf[idx];
                b_n  = max_q;
                if (fire) state_n = S_EXP;
            end
            S_EXP: begin
                op_n = OP_EXP;
                a_n  = tmp_q;
                if (fire) state_n = S_ACC;
            end
            S_ACC: begin
                op_n = OP_ADD;
                a_n  = sum_q;
                b_n  = frame_buf[idx];
                step = fire;
                if (fire) state_n = last_idx ? S_DIV : S_SUB;
            end
            S_DIV: begin
                op_n = OP_DIV;
                a_n  = frame_buf[idx];
                b_n  = sum_q;
                step = fire;
                if (fire && last_idx) state_n = S_LOAD;
            end
            default: state_n = S_LOAD;
        endcase
        if (step) idx_n = last_idx ? '0 : idx + IW'(1);
    end

    // Operands are registered at issue; req drops on capture, so it stays low one cycle between ops.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx         <= '0;
            max_q       <= NEG_INF;
            sum_q       <= '0;
            tmp_q       <= '0;
            fu_req      <= 1'b0;
            fu_op       <= '0;
            fu_a        <= '0;
            fu_b        <= '0;
            softmax_out <= '0;
            out_idx     <= '0;
            valid_out   <= 1'b0;
            out_last    <= 1'b0;
        end else begin
            idx       <= idx_n;
            valid_out <= 1'b0;
            out_last  <= 1'b0;
            if (issue) begin
                fu_req <= 1'b1;
                fu_op  <= op_n;
                fu_a   <= a_n;
                fu_b   <= b_n;
            end else if (fire) begin
                fu_req <= 1'b0;
            end
            if (accept && (order_key(data_in) > order_key(max_q))) max_q <= data_in;
            if (fire) begin
                case (state)
                    S_SUB: tmp_q <= fu_result;
                    S_ACC: sum_q <= fu_result;
                    S_DIV: begin
                        softmax_out <= fu_result;
                        out_idx     <= idx;
                        valid_out   <= 1'b1;
                        out_last    <= last_idx;
                        if (last_idx) begin
                            max_q <= NEG_INF;
                            sum_q <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // NOTE: the frame buffer has no reset; every entry is written before it is read in a frame.
    always_ff @(posedge clk) begin
        if (accept)                        frame_buf[idx] <= data_in;
        else if (fire && state == S_EXP)   frame_buf[idx] <= fu_result;
    end

endmodule

// File: tb/tb_softmax_sequencer.sv
// Directed bench for softmax_sequencer: behavioural FP unit with programmable latency, output
// monitor, and hand-computed / double-precision reference expectations.
module tb_softmax_sequencer;

    localparam int N  = 4;
    localparam int IW = $clog2(N);

    localparam logic [N-1:0][31:0] ONES = {4{32'h3F80_0000}};
    localparam logic [N-1:0][31:0] T2   = {32'hBF00_0000, 32'hC040_0000, 32'hBF80_0000, 32'hC000_0000};
    localparam logic [N-1:0][31:0] T6A  = {32'hBF80_0000, 32'h0000_0000, 32'h8000_0000, 32'hBF80_0000};
    localparam logic [N-1:0][31:0] T6B  = {32'hBF80_0000, 32'h8000_0000, 32'h0000_0000, 32'hBF80_0000};
    localparam logic [N-1:0][31:0] T3A  = {32'h3F40_0000, 32'h4000_0000, 32'hBFA0_0000, 32'h3F00_0000};
    localparam logic [N-1:0][31:0] T3B  = {32'h3FC0_0000, 32'hC080_0000, 32'h4060_0000, 32'h4040_0000};

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_in;
    logic [31:0]   data_in;
    logic          in_ready;
    logic          fu_req;
    logic [1:0]    fu_op;
    logic [31:0]   fu_a, fu_b;
    logic          fu_done;
    logic [31:0]   fu_result;
    logic [31:0]   softmax_out;
    logic          valid_out;
    logic [IW-1:0] out_idx;
    logic          out_last;
    logic          busy;

    softmax_sequencer #(.N(N)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in), .in_ready(in_ready),
        .fu_req(fu_req), .fu_op(fu_op), .fu_a(fu_a), .fu_b(fu_b), .fu_done(fu_done),
        .fu_result(fu_result), .softmax_out(softmax_out), .valid_out(valid_out),
        .out_idx(out_idx), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v,
                         input int tol = 0);
        longint d;
        vec_cnt++;
        d = longint'(obs) - longint'(exp_v);
        if (d < 0) d = -d;
        if (d > longint'(tol)) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (tol %0d) at cycle %0d",
                     tag, obs, exp_v, tol, cyc);
        end
    endtask

    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'h00)      d = {f[31], 63'd0};
        else if (f[30:23] == 8'hFF) d = {f[31], 11'h7FF, f[22:0], 29'd0};
        else                        d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    // Round-to-nearest-even double -> FP32, denormals flushed to zero.
    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [23:0] m;
        int          e;
        d = $realtobits(r);
        e = int'(d[62:52]) - 896;
        if (d[62:52] == 11'd0 || e <= 0) return {d[63], 31'd0};
        if (e >= 255) return {d[63], 8'hFF, 23'd0};
        m = {1'b0, d[51:29]};
        if (d[28] && ((|d[27:0]) || m[0])) m = m + 24'd1;
        if (m[23]) begin
            e = e + 1;
            m = '0;
        end
        if (e >= 255) return {d[63], 8'hFF, 23'd0};
        return {d[63], e[7:0], m[22:0]};
    endfunction

    function automatic logic [31:0] fu_calc(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        real r;
        case (op)
            2'd0:    r = f2r(a) - f2r(b);
            2'd1:    r = $exp(f2r(a));
            2'd2:    r = f2r(a) + f2r(b);
            default: r = f2r(a) / f2r(b);
        endcase
        return r2f(r);
    endfunction

    // FP unit model: done arrives fu_lat cycles after req is first seen (0 = random 1..8).
    int          fixed_lat   = 1;
    bit          spurious_en = 1'b0;
    bit          chk_max_en  = 1'b0;
    bit          chk_exp3_en = 1'b0;
    logic [31:0] exp_max     = '0;
    int          exp_total   = 0;
    int          exp_base    = 0;

    initial begin : fu_model
        bit          active;
        int          cnt, lat;
        logic [1:0]  op_l;
        logic [31:0] a_l, b_l;
        active    = 1'b0;
        cnt       = 0;
        lat       = 1;
        op_l      = '0;
        a_l       = '0;
        b_l       = '0;
        fu_done   = 1'b0;
        fu_result = '0;
        forever begin
            @(negedge clk);
            fu_done = 1'b0;
            if (fu_req) begin
                if (!active) begin
                    active = 1'b1;
                    cnt    = 0;
                    lat    = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 8));
                    op_l   = fu_op;
                    a_l    = fu_a;
                    b_l    = fu_b;
                    if (op_l == 2'd0 && chk_max_en) check("sub_b_is_max", fu_b, exp_max);
                    if (op_l == 2'd1) begin
                        check("exp_b_zero", fu_b, 32'h0);
                        if (chk_exp3_en && exp_total - exp_base == 3) check("exp_idx3_a", fu_a, 32'h0);
                        exp_total++;
                    end
                end else begin
                    cnt++;
                    check("op_stable", 32'(fu_op), 32'(op_l));
                    check("a_stable", fu_a, a_l);
                    check("b_stable", fu_b, b_l);
                    if (cnt == lat) begin
                        fu_done   = 1'b1;
                        fu_result = fu_calc(op_l, a_l, b_l);
                    end
                end
            end else begin
                active = 1'b0;
                if (spurious_en) begin
                    fu_done   = 1'b1;
                    fu_result = 32'h7F7F_FFFF;
                end
            end
        end
    end

    // Output / acceptance monitor.
    logic [31:0] out_data_q [$];
    int          out_idx_q  [$];
    bit          out_last_q [$];
    int          out_cyc_q  [$];
    int          acc_frame    = 0;
    int          last_acc_cyc = 0;
    int          last_out_cyc = 0;
    int          ready_viol   = 0;
    bit          full_seen    = 1'b0;
    bit          gap_pending  = 1'b0;
    bit          b2b_en       = 1'b0;

    initial begin : monitor
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                acc_frame   = 0;
                full_seen   = 1'b0;
                gap_pending = 1'b0;
                ready_viol  = 0;
            end else begin
                if (valid_out) begin
                    out_data_q.push_back(softmax_out);
                    out_idx_q.push_back(int'(out_idx));
                    out_last_q.push_back(out_last);
                    out_cyc_q.push_back(cyc);
                    if (out_last) begin
                        if (b2b_en) begin
                            check("accepts_per_frame", 32'(acc_frame), 32'(N));
                            check("in_ready_low_while_busy", 32'(ready_viol), 32'h0);
                            gap_pending = 1'b1;
                        end
                        acc_frame    = 0;
                        full_seen    = 1'b0;
                        ready_viol   = 0;
                        last_out_cyc = cyc;
                    end
                end else if (full_seen && in_ready) begin
                    ready_viol++;
                end
                if (valid_in && in_ready) begin
                    acc_frame++;
                    last_acc_cyc = cyc;
                    if (gap_pending && b2b_en) check("next_frame_gap", 32'(cyc - last_out_cyc), 32'h0, 1);
                    gap_pending = 1'b0;
                    if (acc_frame == N) full_seen = 1'b1;
                end
            end
        end
    end

    task automatic send(input logic [31:0] x);
        int t;
        for (t = 0; t < 1000; t++) begin
            @(negedge clk);
            valid_in = 1'b1;
            data_in  = x;
            if (in_ready) break;
        end
        if (t == 1000) check("accept_timeout", 32'(in_ready), 32'h1);
    endtask

    task automatic load(input logic [N-1:0][31:0] v, input bit hold);
        for (int i = 0; i < N; i++) send(v[i]);
        if (!hold) begin
            @(negedge clk);
            valid_in = 1'b0;
        end
    endtask

    task automatic wait_out(input int base);
        int t;
        for (t = 0; t < 3000 && out_data_q.size() < base + N; t++) @(negedge clk);
        check("output_count", 32'(out_data_q.size() - base), 32'(N));
    endtask

    task automatic check_frame_const(input int base, input logic [31:0] val);
        if (out_data_q.size() < base + N) return;
        for (int i = 0; i < N; i++) begin
            check("softmax_out", out_data_q[base + i], val);
            check("out_idx", 32'(out_idx_q[base + i]), 32'(i));
            check("out_last", 32'(out_last_q[base + i]), 32'(i == N - 1));
        end
    endtask

    task automatic check_frame_ref(input logic [N-1:0][31:0] v, input int base);
        real mx, s;
        real e [N];
        mx = f2r(v[0]);
        for (int i = 1; i < N; i++) if (f2r(v[i]) > mx) mx = f2r(v[i]);
        s = 0.0;
        for (int i = 0; i < N; i++) begin
            e[i] = $exp(f2r(v[i]) - mx);
            s += e[i];
        end
        if (out_data_q.size() < base + N) return;
        for (int i = 0; i < N; i++) begin
            check("softmax_ulp", out_data_q[base + i], r2f(e[i] / s), 2);
            check("out_idx", 32'(out_idx_q[base + i]), 32'(i));
            check("out_last", 32'(out_last_q[base + i]), 32'(i == N - 1));
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int base, t;
        rst      = 1'b1;
        valid_in = 1'b0;
        data_in  = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_fu_req", 32'(fu_req), 32'h0);
        check("rst_fu_op", 32'(fu_op), 32'h0);
        check("rst_fu_a", fu_a, 32'h0);
        check("rst_fu_b", fu_b, 32'h0);
        check("rst_valid_out", 32'(valid_out), 32'h0);
        check("rst_out_last", 32'(out_last), 32'h0);
        check("rst_out_idx", 32'(out_idx), 32'h0);
        check("rst_softmax_out", softmax_out, 32'h0);
        rst = 1'b0;

        // Four 1.0 inputs, L=1: each output 0.25, 48-cycle latency.
        fixed_lat  = 1;
        chk_max_en = 1'b1;
        exp_max    = 32'h3F80_0000;
        base       = out_data_q.size();
        load(ONES, 1'b0);
        wait_out(base);
        check_frame_const(base, 32'h3E80_0000);
        if (out_cyc_q.size() >= base + N)
            check("frame_latency", 32'(out_cyc_q[base + N - 1] - (last_acc_cyc + 1)), 32'd48);

        // Negative inputs: max -0.5, EXP of idx 3 sees exactly +0.
        exp_max     = 32'hBF00_0000;
        chk_exp3_en = 1'b1;
        exp_base    = exp_total;
        base        = out_data_q.size();
        load(T2, 1'b0);
        wait_out(base);
        check_frame_ref(T2, base);
        chk_exp3_en = 1'b0;

        // Signed zeros: +0 wins over -0 in either order.
        exp_max = 32'h0000_0000;
        base    = out_data_q.size();
        load(T6A, 1'b0);
        wait_out(base);
        check_frame_ref(T6A, base);
        base = out_data_q.size();
        load(T6B, 1'b0);
        wait_out(base);
        check_frame_ref(T6B, base);
        chk_max_en = 1'b0;

        // Random FU latency with spurious done pulses while req is low.
        fixed_lat   = 0;
        spurious_en = 1'b1;
        base        = out_data_q.size();
        load(T3A, 1'b0);
        wait_out(base);
        check_frame_ref(T3A, base);
        base = out_data_q.size();
        load(T3B, 1'b0);
        wait_out(base);
        check_frame_ref(T3B, base);
        spurious_en = 1'b0;

        // valid_in held high across two back-to-back frames.
        fixed_lat = 1;
        b2b_en    = 1'b1;
        base      = out_data_q.size();
        load(ONES, 1'b1);
        load(T3B, 1'b0);
        wait_out(base);
        wait_out(base + N);
        check_frame_const(base, 32'h3E80_0000);
        check_frame_ref(T3B, base + N);
        b2b_en = 1'b0;

        // Reset while the EXP for idx 2 is in flight, then a clean frame.
        fixed_lat = 3;
        exp_base  = exp_total;
        load(ONES, 1'b0);
        for (t = 0; t < 1000; t++) begin
            @(negedge clk);
            #2;
            if (exp_total - exp_base == 3 && fu_req) break;
        end
        check("reached_exp_idx2", 32'(exp_total - exp_base), 32'd3);
        base = out_data_q.size();
        rst  = 1'b1;
        @(negedge clk);
        #2;
        check("abort_fu_req", 32'(fu_req), 32'h0);
        check("abort_valid_out", 32'(valid_out), 32'h0);
        check("abort_in_ready", 32'(in_ready), 32'h1);
        check("abort_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        check("abort_no_output", 32'(out_data_q.size() - base), 32'h0);
        base = out_data_q.size();
        load(ONES, 1'b0);
        wait_out(base);
        check_frame_const(base, 32'h3E80_0000);

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
